// File: rtl/run_sequencer_if.sv
// Requester and engine-side signals of the run sequencer.
// The sequencer connects through master; requesters and the engine connect through slave.
interface run_sequencer_if #(
  parameter int NREQ = 4,
  parameter int CW   = 11
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic [CW-1:0]   result;
  logic            timeout;
  logic            busy;
  logic            eng_done;
  logic [CW-1:0]   eng_count;
  logic            eng_load_mem;
  logic            eng_start;
  logic            eng_reset;

  modport master (
    input  req, eng_done, eng_count,
    output grant, ack, result, timeout, busy, eng_load_mem, eng_start, eng_reset
  );

  modport slave (
    output req, eng_done, eng_count,
    input  grant, ack, result, timeout, busy, eng_load_mem, eng_start, eng_reset
  );
endinterface

// File: rtl/run_sequencer.sv
// Round-robin sharing of one cycle-counting run engine between NREQ requesters,
// with load/start/wait phases, a WAIT-cycle watchdog and a one-cycle ack carrying the count.
module run_sequencer #(
  parameter int NREQ        = 4,
  parameter int CW          = 11,
  parameter int LOAD_CYCLES = 16,
  parameter int TIMEOUT     = 2047
) (
  input logic           clk,
  input logic           reset,
  run_sequencer_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_ARM, S_WAIT, S_ABORT, S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [CW-1:0]   result_q, result_d;
  logic            to_q, to_d;

  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  int unsigned     idx;

  // First set req bit at or above ptr, wrapping around.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = (int'(ptr_q) + i) % NREQ_U;
      if (!pick_any && bus.req[idx]) begin
        pick_any = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    lcnt_d    = lcnt_q;
    wd_d      = wd_q;
    result_d  = result_q;
    to_d      = to_q;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          lcnt_d            = LW'(LOAD_CYCLES);
          to_d              = 1'b0;
          state_nxt         = S_LOAD;
        end
      end
      S_LOAD: begin
        lcnt_d = lcnt_q - 1'b1;
        if (lcnt_q == LW'(1)) state_nxt = S_START;
      end
      S_START: state_nxt = S_ARM;
      // eng_done is still the previous run's level here, so it is not looked at.
      S_ARM: begin
        wd_d      = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.eng_done) begin
          result_d  = bus.eng_count;
          state_nxt = S_RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          result_d  = bus.eng_count;
          to_d      = 1'b1;
          state_nxt = S_ABORT;
        end
      end
      S_ABORT: state_nxt = S_RESP;
      S_RESP: begin
        grant_d   = '0;
        ptr_d     = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      lcnt_q   <= '0;
      wd_q     <= '0;
      result_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      lcnt_q   <= lcnt_d;
      wd_q     <= wd_d;
      result_q <= result_d;
      to_q     <= to_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.ack          = (state == S_RESP) ? grant_q : '0;
  assign bus.result       = result_q;
  assign bus.timeout      = (state == S_RESP) && to_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.eng_load_mem = (state == S_LOAD);
  assign bus.eng_start    = (state == S_START);
  assign bus.eng_reset    = (state == S_ABORT);
endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: stimulus queues expected acks, a monitor checks them,
// and a behavioural engine counts cycles from start and raises done at a chosen count.
module tb_run_sequencer;
  localparam int NREQ = 4;
  localparam int CW   = 11;
  localparam int LC   = 16;
  localparam int TO   = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  run_sequencer_if #(.NREQ(NREQ), .CW(CW)) sif ();

  run_sequencer #(.NREQ(NREQ), .CW(CW), .LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(sif.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: count restarts at start, done rises when count reaches eng_target.
  int          eng_target = 5;
  bit          eng_never  = 1'b0;
  bit          stale_mode = 1'b0;
  logic [CW-1:0] m_cnt;
  logic        m_done, m_run, m_drop;

  always @(posedge clk or posedge reset) begin
    if (reset || sif.eng_reset) begin
      m_cnt <= '0; m_done <= 1'b0; m_run <= 1'b0; m_drop <= 1'b0;
    end else if (sif.eng_start) begin
      m_run  <= 1'b1;
      m_cnt  <= '0;
      m_drop <= stale_mode;
      if (!stale_mode) m_done <= 1'b0;
    end else begin
      if (m_drop) begin
        m_done <= 1'b0;
        m_drop <= 1'b0;
      end
      if (m_run) begin
        m_cnt <= m_cnt + 1'b1;
        if (!eng_never && (int'(m_cnt) + 1 == eng_target)) begin
          m_done <= 1'b1;
          m_run  <= 1'b0;
        end
      end
    end
  end

  assign sif.eng_done  = m_done;
  assign sif.eng_count = m_cnt;

  typedef struct {
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   result;
    logic            to;
    int              aborts;
  } exp_t;
  exp_t sb_q[$];

  task automatic sb_push(input logic [NREQ-1:0] g, input int r, input bit t);
    exp_t e;
    e.grant = g; e.result = CW'(r); e.to = t; e.aborts = t ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // Monitor: per-run counts of load/start/reset cycles, checked against each popped expectation.
  int n_load = 0, n_start = 0, n_rst = 0;
  bit chk_idle = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_load = 0; n_start = 0; n_rst = 0; chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_ack", 32'(sif.busy), 32'd0);
        chk("grant_after_ack", 32'(sif.grant), 32'd0);
        chk_idle = 1'b0;
      end
      if (sif.eng_load_mem) n_load++;
      if (sif.eng_start)    n_start++;
      if (sif.eng_reset)    n_rst++;
      if (sif.ack != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'(sif.ack), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ack",          32'(sif.ack),     32'(e.grant));
          chk("grant_at_ack", 32'(sif.grant),   32'(e.grant));
          chk("result",       32'(sif.result),  32'(e.result));
          chk("timeout",      32'(sif.timeout), 32'(e.to));
          chk("load_cycles",  32'(n_load),      32'(LC));
          chk("start_pulses", 32'(n_start),     32'd1);
          chk("eng_reset_pulses", 32'(n_rst),   32'(e.aborts));
        end
        n_load = 0; n_start = 0; n_rst = 0;
        chk_idle = 1'b1;
      end
    end
  end

  task automatic wait_ack(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sif.ack != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_within_bound", 32'(got), 32'd1);
  endtask

  task automatic wait_sig_start(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sif.eng_start) begin
        got = 1'b1;
        break;
      end
    end
    chk("start_within_bound", 32'(got), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   32'(sif.grant),        32'd0);
    chk({tag, "_ack"},     32'(sif.ack),          32'd0);
    chk({tag, "_result"},  32'(sif.result),       32'd0);
    chk({tag, "_timeout"}, 32'(sif.timeout),      32'd0);
    chk({tag, "_busy"},    32'(sif.busy),         32'd0);
    chk({tag, "_load"},    32'(sif.eng_load_mem), 32'd0);
    chk({tag, "_start"},   32'(sif.eng_start),    32'd0);
    chk({tag, "_engrst"},  32'(sif.eng_reset),    32'd0);
  endtask

  // One run: queue the expectation, raise req, optionally drop it mid-WAIT, release at ack.
  task automatic do_run(input logic [NREQ-1:0] r, input int tgt, input bit stl, input bit nvr,
                        input bit drop, input logic [NREQ-1:0] eg, input int er, input bit eto);
    sb_push(eg, er, eto);
    eng_target = tgt; stale_mode = stl; eng_never = nvr;
    sif.req = r;
    if (drop) begin
      wait_sig_start(100);
      repeat (3) @(negedge clk);
      sif.req = '0;
    end
    wait_ack(200);
    sif.req = '0;
  endtask

  initial begin
    sif.req = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    reset = 1'b0;

    // Reset asserted mid-LOAD: outputs clear asynchronously, no ack for the abandoned run.
    eng_target = 20;
    sif.req = 4'b0010;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = sif.eng_load_mem;
      end
      chk("load_seen", 32'(seen), 32'd1);
    end
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_push(4'b0010, 20, 1'b0);
    @(posedge clk);
    #1 chk("grant_after_release", 32'(sif.grant), 32'b0010);
    wait_ack(200);
    sif.req = '0;

    // Single run: ptr=2, only requester 0 asks.
    do_run(4'b0001, 20, 0, 0, 0, 4'b0001, 20, 0);
    // Engine never finishes: abort at the 24th WAIT cycle with count 24.
    do_run(4'b1000, 0, 0, 1, 0, 4'b1000, 24, 1);

    // Fairness from ptr=0 with every requester asking continuously.
    sb_push(4'b0001, 5, 0);
    sb_push(4'b0010, 5, 0);
    sb_push(4'b0100, 5, 0);
    sb_push(4'b1000, 5, 0);
    sb_push(4'b0001, 5, 0);
    eng_target = 5; stale_mode = 0; eng_never = 0;
    sif.req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack(200);
    sif.req = '0;

    // Stale done held into ARM must not end the run early (would give result 0).
    do_run(4'b0100, 7, 1, 0, 0, 4'b0100, 7, 0);
    // Done on the same WAIT cycle as the watchdog limit wins; requester drops req mid-WAIT.
    do_run(4'b1000, 24, 0, 0, 1, 4'b1000, 24, 0);
    // Done one cycle too late: aborted, count captured at the abort edge.
    do_run(4'b0001, 25, 0, 0, 0, 4'b0001, 24, 1);
    // Normal service after an abort.
    do_run(4'b0100, 3, 0, 0, 0, 4'b0100, 3, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Round-robin scheduler that shares the single cycle-counting run engine (start/load_mem/done/clock_count) between NREQ requesters. For each granted requester it runs three phases: load the engine memory for LOAD_CYCLES cycles, pulse start, then wait for done. It returns the engine's final clock_count to the requester with a one-cycle ack. A watchdog aborts runs that never finish and resets the engine.

## Interface
- NREQ, 4: number of requesters (2..8)
- CW, 11: width of engine clock_count and result
- LOAD_CYCLES, 16: cycles eng_load_mem is held high per run (>=1)
- TIMEOUT, 2047: max WAIT cycles before abort (>=2)

- clk  in  1  system clock, all flops rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  level request per requester; held until its ack
- eng_done  in  1  engine done level
- eng_count  in  CW  engine clock_count
- eng_load_mem  out  1  high throughout LOAD
- eng_start  out  1  one-cycle pulse in START
- eng_reset  out  1  one-cycle pulse on abort (engine's synchronous reset)
- grant  out  NREQ  one-hot owner, held from LOAD through RESP
- ack  out  NREQ  one-cycle pulse to owner in RESP
- result  out  CW  captured count, valid while ack nonzero, else holds
- timeout  out  1  high with ack when the run was aborted
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, START, ARM, WAIT, ABORT, RESP. All outputs come from registers or state decode only, with no combinational path from inputs.
- IDLE: if any req bit is set, pick the first set bit searching upward from ptr with wrap. Set grant to it, load the load counter, go to LOAD. If req==0, stay.
- LOAD: eng_load_mem=1. Stay LOAD_CYCLES cycles, then go to START.
- START: eng_start=1 for one cycle, then go to ARM.
- ARM: one cycle. Ignores the stale eng_done left over from the previous run. Clears the watchdog counter. Go to WAIT.
- WAIT: increment the watchdog each cycle.
  - If eng_done=1: capture eng_count into result and go to RESP.
  - Else if the watchdog reaches TIMEOUT: capture eng_count, set the timeout flag, go to ABORT.
  - eng_done takes priority over the watchdog in the same cycle.
- ABORT: eng_reset=1 for one cycle, then go to RESP.
- RESP: ack = grant for one cycle, timeout as flagged. Set ptr to (granted index + 1) mod NREQ. Clear grant and go to IDLE.
- Requester dropping req after grant: the run still completes and the ack is still issued.
- A req bit that drops before being granted is ignored.
- Arbitration happens only in IDLE. New reqs during a run wait.
- Widths: the watchdog is clog2(TIMEOUT+1) bits and the load counter is clog2(LOAD_CYCLES+1) bits, neither of which wraps. result takes eng_count unmodified.

## Timing
- Reset values: state IDLE, ptr 0; grant, ack, result, timeout, busy, eng_load_mem, eng_start, eng_reset all 0. Reset asserted mid-run abandons the run with no ack; eng_reset is not pulsed.
- With req seen in IDLE at edge 0:
  - grant and busy go high after edge 0.
  - eng_load_mem is high for edges 1..LOAD_CYCLES.
  - eng_start is high for one cycle after edge LOAD_CYCLES.
  - ARM follows, then WAIT.
- eng_done sampled high at WAIT edge d: ack and result are visible during the cycle after edge d.
- Minimum overhead: req to eng_start is LOAD_CYCLES+1 cycles; done to ack is 1 cycle. Abort adds 1 cycle (ABORT) before RESP.
- Back-to-back: IDLE lasts at least one cycle between runs, so the next grant appears 1 cycle after RESP.
- The watchdog counts WAIT cycles only. Timeout fires on the TIMEOUT-th WAIT cycle with eng_done low.

## Test plan
- Reset values: assert reset mid-LOAD with req=4'b0010 → all outputs 0 immediately (async), state IDLE. After release with req still 0010: grant=0010 on the next edge.
- Single run: LOAD_CYCLES=16, req=0001, model engine raises done with count=11'd20 twenty cycles after start → eng_load_mem high 16 cycles, one start pulse, ack=0001 for one cycle with result=20 and timeout=0, busy drops.
- Round-robin fairness: req=1111 held continuously, acks re-raise req → grant order 0001, 0010, 0100, 1000, 0001. No requester is skipped.
- Stale done: engine holds done=1 from the previous run and lowers it one cycle after start → no early RESP; ack only on the new done.
- Timeout: TIMEOUT=8, engine never asserts done → eng_reset pulses once, then ack with timeout=1 and result=eng_count at abort. The next req is served normally.
- Simultaneous: eng_done rises on the same WAIT cycle the watchdog hits TIMEOUT → normal RESP, timeout=0, no eng_reset. A requester dropping req during WAIT still gets its ack.
